// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (IDLE -> ACCESS -> RESP).
// Optional feature macro RAM_ARB_RR_EN: round-robin arbitration instead of fixed processor priority.
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_ack,
   output logic [DATA_W-1:0] p_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;

   logic              grant_s;
   logic              grant_d_s;
   logic              sel_we_s;
   logic [ADDR_W-3:0] sel_word_s;
   logic [DATA_W-1:0] sel_wdata_s;

   logic              busy_s;
   logic              ram_we_s;
   logic              p_ack_s;
   logic              d_ack_s;

   logic              owner_d_r;
   logic              we_r;
   logic              busy_r;
   logic              ram_we_r;
   logic              p_ack_r;
   logic              d_ack_r;
   logic [ADDR_W-3:0] ram_addr_r;
   logic [DATA_W-1:0] ram_din_r;

`ifdef RAM_ARB_RR_EN
   logic              last_d_r;
`endif

   // Byte-offset bits are dropped on purpose: accesses are word aligned.
   logic              unused_s;
   assign unused_s = ^{p_addr[1:0], d_addr[1:0]};

   // Arbitration: pick the requester that would own an access granted this cycle.
   always_comb begin
`ifdef RAM_ARB_RR_EN
      if (p_req && d_req) begin
         grant_d_s = ~last_d_r;
      end else begin
         grant_d_s = d_req;
      end
`else
      grant_d_s = d_req & ~p_req;
`endif
      if (grant_d_s) begin
         sel_we_s    = d_we;
         sel_word_s  = d_addr[ADDR_W-1:2];
         sel_wdata_s = d_wdata;
      end else begin
         sel_we_s    = p_we;
         sel_word_s  = p_addr[ADDR_W-1:2];
         sel_wdata_s = p_wdata;
      end
   end

   // Next-state logic; arbitration only happens from IDLE.
   always_comb begin
      state_s = state_r;
      grant_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (p_req || d_req) begin
               grant_s = 1'b1;
               state_s = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (we_r) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, so they line up with the state they belong to.
   always_comb begin
      busy_s   = (state_s != IDLE);
      ram_we_s = grant_s & sel_we_s;
      p_ack_s  = 1'b0;
      d_ack_s  = 1'b0;
      if (grant_s && sel_we_s) begin
         p_ack_s = ~grant_d_s;
         d_ack_s = grant_d_s;
      end else if ((state_r == ACCESS) && !we_r) begin
         p_ack_s = ~owner_d_r;
         d_ack_s = owner_d_r;
      end else begin
         p_ack_s = 1'b0;
         d_ack_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Command latch and registered outputs; reset drops any in-flight write before it reaches RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_d_r  <= 1'b0;
         we_r       <= 1'b0;
         busy_r     <= 1'b0;
         ram_we_r   <= 1'b0;
         p_ack_r    <= 1'b0;
         d_ack_r    <= 1'b0;
         ram_addr_r <= {(ADDR_W-2){1'b0}};
         ram_din_r  <= {DATA_W{1'b0}};
      end else begin
         busy_r   <= busy_s;
         ram_we_r <= ram_we_s;
         p_ack_r  <= p_ack_s;
         d_ack_r  <= d_ack_s;
         if (grant_s) begin
            owner_d_r  <= grant_d_s;
            we_r       <= sel_we_s;
            ram_addr_r <= sel_word_s;
            ram_din_r  <= sel_wdata_s;
         end else begin
            owner_d_r  <= owner_d_r;
            we_r       <= we_r;
            ram_addr_r <= ram_addr_r;
            ram_din_r  <= ram_din_r;
         end
      end
   end

`ifdef RAM_ARB_RR_EN
   // Remembers who was granted last so the other side wins the next tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d_r <= 1'b0;
      end else if (grant_s) begin
         last_d_r <= grant_d_s;
      end else begin
         last_d_r <= last_d_r;
      end
   end
`endif

   assign busy     = busy_r;
   assign ram_we   = ram_we_r;
   assign ram_addr = ram_addr_r;
   assign ram_din  = ram_din_r;
   assign p_ack    = p_ack_r;
   assign d_ack    = d_ack_r;

   // Read data comes straight from the RAM during the response cycle and is zero otherwise.
   assign p_rdata = (p_ack_r && !we_r) ? ram_dout : {DATA_W{1'b0}};
   assign d_rdata = (d_ack_r && !we_r) ? ram_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model, directed scenarios and random traffic.
// Build with RAM_ARB_RR_EN defined to check the round-robin variant.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        p_req = 1'b0, p_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [7:0]  p_addr = 8'd0, d_addr = 8'd0;
   logic [31:0] p_wdata = 32'd0, d_wdata = 32'd0;
   logic        p_ack, d_ack, ram_we, busy;
   logic [31:0] p_rdata, d_rdata, ram_din, ram_dout;
   logic [5:0]  ram_addr;

`ifdef RAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_ack(p_ack), .p_rdata(p_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous RAM with one cycle read latency.
   logic [31:0] ram_mem [0:63];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   // Reference model: one transaction in flight, described by its owner, kind and age in cycles.
   logic [31:0] mem_model [0:63];
   bit          m_active, m_owner_d, m_we, m_last_d;
   int          m_age;
   logic [5:0]  m_addr;
   logic [31:0] m_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_owner_d = 1'b0;
      m_we      = 1'b0;
      m_last_d  = 1'b0;
      m_age     = 0;
      m_addr    = 6'd0;
      m_wdata   = 32'd0;
   endtask

   // Advance the model by one rising edge using the inputs the DUT sampled at that edge.
   task automatic model_step();
      bit d_win;
      if (rst) begin
         model_reset();
      end else if (m_active) begin
         if (m_we) begin
            mem_model[m_addr] = m_wdata;
            m_active = 1'b0;
         end else if (m_age == 0) begin
            m_age = 1;
         end else begin
            m_active = 1'b0;
         end
      end else if (p_req || d_req) begin
         if (p_req && d_req) d_win = RR ? !m_last_d : 1'b0;
         else                d_win = d_req;
         m_active  = 1'b1;
         m_age     = 0;
         m_owner_d = d_win;
         m_last_d  = d_win;
         m_we      = d_win ? d_we : p_we;
         m_addr    = d_win ? d_addr[7:2] : p_addr[7:2];
         m_wdata   = d_win ? d_wdata : p_wdata;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Compare process: every output against the model, every cycle, away from the active edge.
   always @(negedge clk) begin
      bit          ack_e;
      logic [31:0] rd_e;
      ack_e = m_active && (m_we || m_age == 1);
      rd_e  = (ack_e && !m_we) ? mem_model[m_addr] : 32'd0;
      chk("busy",     {31'd0, busy},   {31'd0, m_active});
      chk("ram_we",   {31'd0, ram_we}, {31'd0, m_active && m_we});
      chk("ram_addr", {26'd0, ram_addr}, {26'd0, m_addr});
      chk("ram_din",  ram_din, m_wdata);
      chk("p_ack",    {31'd0, p_ack},  {31'd0, ack_e && !m_owner_d});
      chk("d_ack",    {31'd0, d_ack},  {31'd0, ack_e && m_owner_d});
      chk("p_rdata",  p_rdata, m_owner_d ? 32'd0 : rd_e);
      chk("d_rdata",  d_rdata, m_owner_d ? rd_e : 32'd0);
      chk("ack_excl", {31'd0, p_ack & d_ack}, 32'd0);
   end

   task automatic p_cmd(input logic we, input logic [7:0] a, input logic [31:0] wd);
      p_req = 1'b1; p_we = we; p_addr = a; p_wdata = wd;
   endtask

   task automatic d_cmd(input logic we, input logic [7:0] a, input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
   endtask

   initial begin
      int acks;
      logic [3:0] seq;
      logic [3:0] seq_exp;
      for (int i = 0; i < 64; i++) begin
         ram_mem[i]   = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
         mem_model[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      end
      model_reset();
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_busy",  {31'd0, busy},   32'd0);
      chk("rst_ramwe", {31'd0, ram_we}, 32'd0);
      chk("rst_din",   ram_din, 32'd0);
      rst = 1'b0;
      tick();

      // Processor write of 0xDEADBEEF to byte address 0x14 (word 5).
      p_cmd(1'b1, 8'h14, 32'hDEAD_BEEF);
      tick();
      chk("w_ram_addr", {26'd0, ram_addr}, 32'd5);
      chk("w_ram_we",   {31'd0, ram_we}, 32'd1);
      chk("w_p_ack",    {31'd0, p_ack},  32'd1);
      chk("w_d_ack",    {31'd0, d_ack},  32'd0);
      p_req = 1'b0;
      tick();
      chk("w_done_we",   {31'd0, ram_we}, 32'd0);
      chk("w_done_busy", {31'd0, busy},   32'd0);

      // Processor read back of 0x14: ack on the second cycle after grant.
      p_cmd(1'b0, 8'h17, 32'h0);
      tick();
      chk("r_acc_ack", {31'd0, p_ack},  32'd0);
      chk("r_acc_we",  {31'd0, ram_we}, 32'd0);
      tick();
      chk("r_resp_ack",   {31'd0, p_ack}, 32'd1);
      chk("r_resp_rdata", p_rdata, 32'hDEAD_BEEF);
      p_req = 1'b0;
      tick();
      chk("r_idle_rdata", p_rdata, 32'd0);

      // Secondary-only write so that, with round-robin, the processor wins the next tie.
      d_cmd(1'b1, 8'h28, 32'h0BAD_0001);
      tick();
      d_req = 1'b0;
      tick();

      // Both requesters held high for four writes.
      p_cmd(1'b1, 8'h20, 32'h1111_0000);
      d_cmd(1'b1, 8'h24, 32'h2222_0000);
      acks = 0;
      seq = 4'd0;
      for (int c = 0; c < 20 && acks < 4; c++) begin
         tick();
         if (p_ack || d_ack) begin
            seq[acks] = d_ack;
            acks++;
            p_wdata = p_wdata + 32'd1;
            d_wdata = d_wdata + 32'd1;
            if (acks == 4) begin
               p_req = 1'b0;
               d_req = 1'b0;
            end
         end
      end
      p_req = 1'b0;
      d_req = 1'b0;
      seq_exp = RR ? 4'b1010 : 4'b0000;
      chk("tie_ack_count", 32'(acks), 32'd4);
      chk("tie_grant_seq", {28'd0, seq}, {28'd0, seq_exp});
      tick();

      // Secondary write arriving while a processor read is in its response cycle.
      p_cmd(1'b0, 8'h14, 32'h0);
      tick();
      tick();
      chk("ovl_p_ack", {31'd0, p_ack}, 32'd1);
      p_req = 1'b0;
      d_cmd(1'b1, 8'h30, 32'hCAFE_F00D);
      tick();
      chk("ovl_idle_busy", {31'd0, busy},  32'd0);
      chk("ovl_idle_dack", {31'd0, d_ack}, 32'd0);
      tick();
      chk("ovl_d_ack",    {31'd0, d_ack}, 32'd1);
      chk("ovl_ram_addr", {26'd0, ram_addr}, 32'd12);
      d_req = 1'b0;
      tick();

      // Reset in the ACCESS cycle of a write must abandon it.
      p_cmd(1'b1, 8'h08, 32'h1111_2222);
      tick();
      p_req = 1'b0;
      tick();
      p_cmd(1'b1, 8'h08, 32'h9999_9999);
      tick();
      chk("ar_pre_we", {31'd0, ram_we}, 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("ar_busy",  {31'd0, busy},   32'd0);
      chk("ar_ramwe", {31'd0, ram_we}, 32'd0);
      chk("ar_pack",  {31'd0, p_ack},  32'd0);
      p_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      p_cmd(1'b0, 8'h08, 32'h0);
      tick();
      tick();
      chk("ar_read_back", p_rdata, 32'h1111_2222);
      p_req = 1'b0;
      tick();

      // Processor drops its read request right after grant.
      p_cmd(1'b0, 8'h14, 32'h0);
      tick();
      p_req = 1'b0;
      acks = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (p_ack) acks++;
      end
      chk("drop_ack_once", 32'(acks), 32'd1);
      chk("drop_idle",     {31'd0, busy}, 32'd0);

      // Random traffic with occasional asynchronous resets.
      for (int c = 0; c < 1500; c++) begin
         if (rst) rst = 1'b0;
         if (!p_req) begin
            if ($urandom_range(0, 2) == 0) p_cmd(1'($urandom), 8'($urandom), $urandom);
         end else if (p_ack) begin
            if ($urandom_range(0, 3) != 0) p_req = 1'b0;
            else p_cmd(1'($urandom), 8'($urandom), $urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            p_req = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            p_addr  = 8'($urandom);
            p_wdata = $urandom;
         end
         if (!d_req) begin
            if ($urandom_range(0, 2) == 0) d_cmd(1'($urandom), 8'($urandom), $urandom);
         end else if (d_ack) begin
            if ($urandom_range(0, 3) != 0) d_req = 1'b0;
            else d_cmd(1'($urandom), 8'($urandom), $urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            d_req = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            d_addr  = 8'($urandom);
            d_wdata = $urandom;
         end
         if ($urandom_range(0, 199) == 0) begin
            #2;
            rst = 1'b1;
            model_reset();
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
